// File: rtl/ddr_ctl1_sequencer_if.sv
// Request/response bundle and DdrCtl1 instruction channel seen by ddr_ctl1_sequencer.
// slave is the sequencer's side; master is the requester / DdrCtl1 side.
interface ddr_ctl1_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [11:0] ctl_inst;
    logic        ctl_inst_en;
    logic [31:0] ctl_page;
    logic        ctl_ready;

    modport slave (
        input  req_valid, req_write, req_addr, req_data, ctl_page, ctl_ready,
        output req_ready, rsp_valid, rsp_data, busy, ctl_inst, ctl_inst_en
    );

    modport master (
        output req_valid, req_write, req_addr, req_data, ctl_page, ctl_ready,
        input  req_ready, rsp_valid, rsp_data, busy, ctl_inst, ctl_inst_en
    );
endinterface

// File: rtl/ddr_ctl1_sequencer.sv
// Expands 32-bit word requests into the DdrCtl1 LAn/LDn/WRP/RDP instruction stream,
// skipping address bytes already held in DdrCtl1's address register.
`ifndef DdrCtl1_NOP
`define DdrCtl1_NOP 4'h0
`define DdrCtl1_LA0 4'h1
`define DdrCtl1_LA1 4'h2
`define DdrCtl1_LA2 4'h3
`define DdrCtl1_LA3 4'h4
`define DdrCtl1_LD0 4'h5
`define DdrCtl1_LD1 4'h6
`define DdrCtl1_LD2 4'h7
`define DdrCtl1_LD3 4'h8
`define DdrCtl1_WRP 4'h9
`define DdrCtl1_RDP 4'hA
`endif

module ddr_ctl1_sequencer #(
    parameter int unsigned GUARD_CYCLES   = 2,
    parameter bit          SKIP_SAME_ADDR = 1'b1
) (
    input logic                 clock,
    input logic                 reset,
    ddr_ctl1_sequencer_if.slave bus
);
    localparam int unsigned       GuardW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GuardW-1:0] GuardLast = GuardW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StCmd, StGuard, StWait} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, data_q, shadow_q, shadow_d, rsp_data_q;
    logic              write_q, rsp_valid_q, rsp_load, accept, inst_en;
    logic [3:0]        mask_q, mask_d, addr_vld_q, addr_vld_d, load_mask;
    logic [1:0]        byte_cnt_q, byte_cnt_d, la_idx;
    logic [GuardW-1:0] guard_q, guard_d;
    logic [11:0]       inst;
    logic [7:0]        la_byte, ld_byte;

    function automatic logic [3:0] la_op(input logic [1:0] n);
        logic [3:0] op;
        op = `DdrCtl1_LA0;
        unique case (n)
            2'd0: op = `DdrCtl1_LA0;
            2'd1: op = `DdrCtl1_LA1;
            2'd2: op = `DdrCtl1_LA2;
            2'd3: op = `DdrCtl1_LA3;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] ld_op(input logic [1:0] n);
        logic [3:0] op;
        op = `DdrCtl1_LD0;
        unique case (n)
            2'd0: op = `DdrCtl1_LD0;
            2'd1: op = `DdrCtl1_LD1;
            2'd2: op = `DdrCtl1_LD2;
            2'd3: op = `DdrCtl1_LD3;
        endcase
        return op;
    endfunction

    // A byte must be (re)loaded unless DdrCtl1 is known to already hold it.
    always_comb begin
        load_mask = '0;
        for (int n = 0; n < 4; n++) begin
            load_mask[n] = !addr_vld_q[n] || (shadow_q[8*n +: 8] != bus.req_addr[8*n +: 8]) ||
                           !SKIP_SAME_ADDR;
        end
    end

    always_comb begin
        la_idx = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (mask_q[n]) la_idx = 2'(n);
        end
    end

    assign la_byte = addr_q[{la_idx, 3'b000} +: 8];
    assign ld_byte = data_q[{byte_cnt_q, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        byte_cnt_d = byte_cnt_q;
        guard_d    = guard_q;
        shadow_d   = shadow_q;
        addr_vld_d = addr_vld_q;
        accept     = 1'b0;
        rsp_load   = 1'b0;
        inst       = {`DdrCtl1_NOP, 8'h00};
        inst_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    mask_d     = load_mask;
                    byte_cnt_d = 2'd0;
                    if (load_mask != 4'b0000) state_d = StAddr;
                    else if (bus.req_write)   state_d = StData;
                    else                      state_d = StCmd;
                end
            end
            StAddr: begin
                inst    = {la_op(la_idx), la_byte};
                inst_en = bus.ctl_ready;
                if (bus.ctl_ready) begin
                    mask_d[la_idx]                  = 1'b0;
                    shadow_d[{la_idx, 3'b000} +: 8] = la_byte;
                    addr_vld_d[la_idx]              = 1'b1;
                    if (mask_d == 4'b0000) state_d = write_q ? StData : StCmd;
                end
            end
            StData: begin
                inst    = {ld_op(byte_cnt_q), ld_byte};
                inst_en = bus.ctl_ready;
                if (bus.ctl_ready) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = StCmd;
                end
            end
            StCmd: begin
                inst    = {write_q ? `DdrCtl1_WRP : `DdrCtl1_RDP, 8'h00};
                inst_en = bus.ctl_ready;
                if (bus.ctl_ready) begin
                    guard_d = '0;
                    state_d = (GUARD_CYCLES == 0) ? StWait : StGuard;
                end
            end
            // DdrCtl1 drops ready late after WRP/RDP, so ready is not trusted here.
            StGuard: begin
                if (guard_q == GuardLast) state_d = StWait;
                else                      guard_d = guard_q + GuardW'(1);
            end
            StWait: begin
                if (bus.ctl_ready) begin
                    state_d  = StIdle;
                    rsp_load = !write_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            mask_q      <= '0;
            byte_cnt_q  <= '0;
            guard_q     <= '0;
            shadow_q    <= '0;
            addr_vld_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            byte_cnt_q  <= byte_cnt_d;
            guard_q     <= guard_d;
            shadow_q    <= shadow_d;
            addr_vld_q  <= addr_vld_d;
            rsp_valid_q <= rsp_load;
            if (rsp_load) rsp_data_q <= bus.ctl_page;
            if (accept) begin
                addr_q  <= bus.req_addr;
                data_q  <= bus.req_data;
                write_q <= bus.req_write;
            end
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.ctl_inst    = inst;
    assign bus.ctl_inst_en = inst_en;
endmodule

// File: tb/tb_ddr_ctl1_sequencer.sv
// Bench for ddr_ctl1_sequencer: directed scenarios plus randomized requests, checked
// against an instruction-queue model of the expected DdrCtl1 stream and a page memory.
`ifndef DdrCtl1_NOP
`define DdrCtl1_NOP 4'h0
`define DdrCtl1_LA0 4'h1
`define DdrCtl1_LA1 4'h2
`define DdrCtl1_LA2 4'h3
`define DdrCtl1_LA3 4'h4
`define DdrCtl1_LD0 4'h5
`define DdrCtl1_LD1 4'h6
`define DdrCtl1_LD2 4'h7
`define DdrCtl1_LD3 4'h8
`define DdrCtl1_WRP 4'h9
`define DdrCtl1_RDP 4'hA
`endif

module tb_ddr_ctl1_sequencer;
    localparam int unsigned GuardCycles = 2;
    localparam bit          SkipSame    = 1'b1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ddr_ctl1_sequencer_if bus ();

    ddr_ctl1_sequencer #(
        .GUARD_CYCLES  (GuardCycles),
        .SKIP_SAME_ADDR(SkipSame)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic [3:0]  la_ops[4] = '{`DdrCtl1_LA0, `DdrCtl1_LA1, `DdrCtl1_LA2, `DdrCtl1_LA3};
    logic [3:0]  ld_ops[4] = '{`DdrCtl1_LD0, `DdrCtl1_LD1, `DdrCtl1_LD2, `DdrCtl1_LD3};
    logic [7:0]  m_shadow[4];
    bit          m_vld[4];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] last_rsp = 32'h0;
    logic [11:0] nop_inst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_inst_en"}, 32'(bus.ctl_inst_en), 32'd0);
        chk({tag, "_inst"}, 32'(bus.ctl_inst), 32'(nop_inst));
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    endtask

    // One request end to end. pre=1: the accept already happened on the previous edge.
    // abort_at>=0: pulse reset once that many instructions have been strobed.
    task automatic run_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input int stall_at, input int stall_len, input bit rnd,
                           input bit hold, input bit pre, input int abort_at);
        logic [11:0] q[$];
        int          pos, stall_left, wait_lo;
        bit          stall_done, rdy;
        logic [31:0] page;
        for (int n = 0; n < 4; n++) begin
            if (!m_vld[n] || m_shadow[n] != a[8*n +: 8] || !SkipSame) begin
                q.push_back({la_ops[n], a[8*n +: 8]});
                m_shadow[n] = a[8*n +: 8];
                m_vld[n]    = 1'b1;
            end
        end
        if (wr) for (int n = 0; n < 4; n++) q.push_back({ld_ops[n], d[8*n +: 8]});
        q.push_back({wr ? `DdrCtl1_WRP : `DdrCtl1_RDP, 8'h00});
        page = mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);

        if (!pre) begin
            @(posedge clock); #1;
            bus.req_valid = 1'b1;
            bus.req_write = wr;
            bus.req_addr  = a;
            bus.req_data  = d;
            bus.ctl_ready = 1'b1;
            @(negedge clock);
            chk("accept_req_ready", 32'(bus.req_ready), 32'd1);
            chk("accept_busy", 32'(bus.busy), 32'd0);
        end

        pos        = 0;
        stall_left = 0;
        stall_done = 1'b0;
        while (pos < q.size()) begin
            if (pos == abort_at) begin
                @(posedge clock); #1;
                bus.req_valid = 1'b0;
                reset         = 1'b1;
                #1;
                chk_reset_outputs("abort");
                @(negedge clock);
                reset = 1'b0;
                for (int n = 0; n < 4; n++) m_vld[n] = 1'b0;
                last_rsp = 32'h0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clock); #1;
                    bus.ctl_ready = 1'b1;
                    @(negedge clock);
                    chk("post_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                    chk("post_abort_busy", 32'(bus.busy), 32'd0);
                end
                return;
            end
            @(posedge clock); #1;
            bus.req_valid = hold;
            if (pos == stall_at && !stall_done) begin
                stall_left = stall_len;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.ctl_ready = rdy;
            @(negedge clock);
            chk("issue_inst_en", 32'(bus.ctl_inst_en), 32'(rdy));
            chk("issue_inst", 32'(bus.ctl_inst), 32'(q[pos]));
            chk("issue_busy", 32'(bus.busy), 32'd1);
            chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
            if (rdy) pos++;
        end

        for (int g = 0; g < GuardCycles; g++) begin
            @(posedge clock); #1;
            bus.req_valid = hold;
            bus.ctl_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("guard_inst_en", 32'(bus.ctl_inst_en), 32'd0);
            chk("guard_inst", 32'(bus.ctl_inst), 32'(nop_inst));
            chk("guard_busy", 32'(bus.busy), 32'd1);
            chk("guard_req_ready", 32'(bus.req_ready), 32'd0);
        end

        wait_lo = $urandom_range(0, 3);
        for (int w = 0; w <= wait_lo; w++) begin
            @(posedge clock); #1;
            bus.req_valid = hold;
            bus.ctl_ready = (w == wait_lo);
            bus.ctl_page  = (w == wait_lo) ? page : $urandom;
            @(negedge clock);
            chk("wait_busy", 32'(bus.busy), 32'd1);
            chk("wait_inst_en", 32'(bus.ctl_inst_en), 32'd0);
            chk("wait_req_ready", 32'(bus.req_ready), 32'd0);
            chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        if (wr) mem[a] = d;
        else    last_rsp = page;

        @(posedge clock); #1;
        bus.req_valid = hold;
        bus.ctl_ready = 1'($urandom_range(0, 1));
        bus.ctl_page  = $urandom;
        @(negedge clock);
        chk("done_req_ready", 32'(bus.req_ready), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_inst_en", 32'(bus.ctl_inst_en), 32'd0);
        chk("done_rsp_valid", 32'(bus.rsp_valid), 32'(!wr));
        chk("done_rsp_data", bus.rsp_data, last_rsp);

        if (!hold) begin
            @(posedge clock); #1;
            bus.req_valid = 1'b0;
            @(negedge clock);
            chk("after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("after_rsp_data", bus.rsp_data, last_rsp);
            chk("after_req_ready", 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] prev_addr, a, d;
        bit          wr;
        nop_inst      = {`DdrCtl1_NOP, 8'h00};
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.ctl_page  = '0;
        bus.ctl_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            m_vld[n]    = 1'b0;
            m_shadow[n] = 8'h00;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Full write, then same-page read, then one-byte address change with a stall on LD1.
        run_req(1'b1, 32'h002B_3F12, 32'hDDCC_BBAA, -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_req(1'b0, 32'h002B_3F12, 32'h0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_req(1'b1, 32'h012B_3F12, 32'h2211_FFEE, 2, 3, 1'b0, 1'b0, 1'b0, -1);

        // Reset while LD2 is pending, then the next write must reload all four LAn.
        run_req(1'b1, 32'h002B_3F12, 32'h4433_2211, -1, 0, 1'b0, 1'b0, 1'b0, 3);
        run_req(1'b1, 32'h002B_3F12, 32'hDDCC_BBAA, -1, 0, 1'b0, 1'b0, 1'b0, -1);

        // req_valid held through the whole sequence: accepted again in the first IDLE cycle.
        run_req(1'b1, 32'h002B_3F12, 32'h1357_9BDF, -1, 0, 1'b0, 1'b1, 1'b0, -1);
        run_req(1'b1, 32'h002B_3F12, 32'h1357_9BDF, -1, 0, 1'b0, 1'b0, 1'b1, -1);
        run_req(1'b0, 32'h002B_3F12, 32'h0, -1, 0, 1'b1, 1'b0, 1'b0, -1);

        prev_addr = 32'h002B_3F12;
        for (int r = 0; r < 40; r++) begin
            for (int n = 0; n < 4; n++) begin
                a[8*n +: 8] = ($urandom_range(0, 1) == 0) ? prev_addr[8*n +: 8]
                                                          : 8'($urandom_range(0, 3));
            end
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            run_req(wr, a, d, -1, 0, 1'b1, 1'b0, 1'b0, -1);
            prev_addr = a;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
